// File: rtl/aha_sif_pkg.sv
// Shared definitions for the AXI-to-SIF write bridge: burst/response encodings,
// FSM state type and the per-beat address stepping rule.
package aha_sif_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Address arithmetic is done at this width and truncated by the caller,
    // which keeps the helper independent of the instance address width.
    localparam int ADDR_CALC_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } sif_wr_state_t;

    // Address of the beat following 'addr'; burst must already be FIXED/INCR/WRAP.
    function automatic logic [ADDR_CALC_W-1:0] next_beat_addr(
        input logic [ADDR_CALC_W-1:0] addr,
        input logic [2:0]             size,
        input logic [1:0]             burst,
        input logic [ADDR_CALC_W-1:0] mask
    );
        logic [ADDR_CALC_W-1:0] step;
        step = {{(ADDR_CALC_W-1){1'b0}}, 1'b1} << size;
        case (burst)
            BURST_FIXED: next_beat_addr = addr;
            BURST_WRAP:  next_beat_addr = (addr & ~mask) | ((addr + step) & mask);
            default:     next_beat_addr = (addr & ~(step - 1'b1)) + step;
        endcase
    endfunction

endpackage

// File: rtl/aha_sif_out_reg.sv
// One-entry valid/ready output register. Accepts a new entry whenever it is
// empty or being drained in the same cycle, giving one transfer per cycle.
module aha_sif_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Load on an input transfer, otherwise empty (and zero) the entry once consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end
    end

endmodule

// File: rtl/aha_axi_to_sif_write_burst.sv
// AXI4 write-channel slave that turns one outstanding burst into a registered,
// back-pressurable SIF write stream with locally computed beat addresses.
// Optional protocol checking (SLVERR responses) is built when the macro
// AHA_SIF_WRITE_ERR_EN is defined.
module aha_axi_to_sif_write_burst
    import aha_sif_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int ADDR_W = 32,
    parameter  int ID_W   = 4,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [7:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [ADDR_W-1:0] SIF_ADDR,
    output logic [STRB_W-1:0] SIF_STRB,
    output logic [DATA_W-1:0] SIF_DATA,
    output logic              SIF_WE,
    input  logic              SIF_READY
);

    localparam logic [2:0] SIZE_MAX  = 3'($clog2(STRB_W));
    localparam int         PAYLOAD_W = ADDR_W + STRB_W + DATA_W;

    sif_wr_state_t     state_reg;
    logic              awready_reg;
    logic              bvalid_reg;
    logic [ID_W-1:0]   id_reg;
    logic [7:0]        len_reg;
    logic [7:0]        cnt_reg;
    logic [2:0]        size_reg;
    logic [1:0]        burst_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] mask_reg;

    logic [2:0]        size_next;
    logic [1:0]        burst_next;
    logic [ADDR_W-1:0] mask_next;
    logic [ADDR_W-1:0] addr_next;

    logic aw_hs;
    logic w_hs;
    logic wready;
    logic last_beat;
    logic out_in_valid;
    logic out_in_ready;
    logic [PAYLOAD_W-1:0] out_payload;

    // Oversized beats and reserved bursts are normalised before latching so the
    // address path only ever sees legal FIXED/INCR/WRAP with SIZE <= bus width.
    always_comb begin
        size_next  = (AWSIZE > SIZE_MAX) ? SIZE_MAX : AWSIZE;
        burst_next = (AWBURST == 2'b11) ? BURST_INCR : AWBURST;
        mask_next  = ADDR_W'(((ADDR_CALC_W'(AWLEN) + 1'b1) << size_next) - 1'b1);
        addr_next  = ADDR_W'(next_beat_addr(ADDR_CALC_W'(addr_reg), size_reg,
                                            burst_reg, ADDR_CALC_W'(mask_reg)));
    end

    assign aw_hs     = AWVALID && awready_reg;
    assign wready    = (state_reg == DATA) && out_in_ready;
    assign w_hs      = WVALID && wready;
    assign last_beat = (cnt_reg == len_reg);

    assign AWREADY = awready_reg;
    assign WREADY  = wready;
    assign BVALID  = bvalid_reg;
    assign BID     = id_reg;

`ifdef AHA_SIF_WRITE_ERR_EN
    logic burst_err_reg;
    logic proto_err_reg;
    logic burst_err_next;

    // Illegal bursts are recognised on the raw AW fields, before normalisation.
    always_comb begin
        burst_err_next = (AWBURST == 2'b11) || (AWSIZE > SIZE_MAX) ||
                         ((AWBURST == BURST_WRAP) &&
                          !((AWLEN == 8'd1) || (AWLEN == 8'd3) ||
                            (AWLEN == 8'd7) || (AWLEN == 8'd15)));
    end

    // Error flags: burst-level flag captured at AW, WLAST mismatch is sticky per burst.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            burst_err_reg <= 1'b0;
            proto_err_reg <= 1'b0;
        end else if (aw_hs) begin
            burst_err_reg <= burst_err_next;
            proto_err_reg <= 1'b0;
        end else if (w_hs && (WLAST != last_beat)) begin
            proto_err_reg <= 1'b1;
        end
    end

    // Beats of a flagged burst are consumed but never reach the SIF side.
    assign out_in_valid = w_hs && !burst_err_reg;
    assign BRESP        = (bvalid_reg && (burst_err_reg || proto_err_reg)) ? RESP_SLVERR : RESP_OKAY;
`else
    // The beat counter alone terminates a burst, so WLAST is not needed here.
    logic unused_wlast;
    assign unused_wlast = WLAST;

    assign out_in_valid = w_hs;
    assign BRESP        = RESP_OKAY;
`endif

    aha_sif_out_reg #(
        .W (PAYLOAD_W)
    ) u_out_reg (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .in_valid  (out_in_valid),
        .in_ready  (out_in_ready),
        .in_data   ({addr_reg, WSTRB, WDATA}),
        .out_valid (SIF_WE),
        .out_ready (SIF_READY),
        .out_data  (out_payload)
    );

    assign {SIF_ADDR, SIF_STRB, SIF_DATA} = out_payload;

    // Burst sequencing: accept AW, count W beats, wait for the last SIF commit, respond.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_reg   <= IDLE;
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            id_reg      <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            size_reg    <= '0;
            burst_reg   <= BURST_FIXED;
            addr_reg    <= '0;
            mask_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    awready_reg <= 1'b1;
                    if (aw_hs) begin
                        awready_reg <= 1'b0;
                        id_reg      <= AWID;
                        len_reg     <= AWLEN;
                        size_reg    <= size_next;
                        burst_reg   <= burst_next;
                        addr_reg    <= AWADDR;
                        mask_reg    <= mask_next;
                        cnt_reg     <= '0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        addr_reg <= addr_next;
                        if (last_beat) begin
                            state_reg <= DRAIN;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    // An empty register covers bursts whose beats were all suppressed.
                    if (!SIF_WE || SIF_READY) begin
                        bvalid_reg <= 1'b1;
                        state_reg  <= RESP;
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aha_axi_to_sif_write_burst.sv
// Self-checking bench for aha_axi_to_sif_write_burst: directed bursts followed
// by randomised bursts, compared against an address/beat model built from the
// burst rules. Error-path steps are included when AHA_SIF_WRITE_ERR_EN is defined.
module tb_aha_axi_to_sif_write_burst;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;
`ifdef AHA_SIF_WRITE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              ACLK;
    logic              ARESETn;
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] SIF_ADDR;
    logic [STRB_W-1:0] SIF_STRB;
    logic [DATA_W-1:0] SIF_DATA;
    logic              SIF_WE;
    logic              SIF_READY;

    aha_axi_to_sif_write_burst #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .ID_W   (ID_W)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWBURST   (AWBURST),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .SIF_ADDR  (SIF_ADDR),
        .SIF_STRB  (SIF_STRB),
        .SIF_DATA  (SIF_DATA),
        .SIF_WE    (SIF_WE),
        .SIF_READY (SIF_READY)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  s;
        logic [63:0] d;
    } beat_t;

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    first_we    = -1;
    int    last_we     = -1;
    int    rdy_mode    = 0;
    beat_t exp_q[$];

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Beat address from the burst rules: start + i*bytes for INCR (aligned after
    // the first beat), constant for FIXED, and modulo the burst span for WRAP.
    function automatic logic [31:0] ref_addr(input logic [31:0] start, input int i,
                                             input int len, input int size, input int burst);
        int          bytes;
        logic [31:0] total;
        logic [31:0] off;
        bytes = 1 << ((size > 3) ? 3 : size);
        if (burst == 0) return start;
        if (burst == 2) begin
            total = 32'((len + 1) * bytes);
            off   = start % total;
            return (start - off) + ((off + 32'(i * bytes)) % total);
        end
        if (i == 0) return start;
        return (start - (start % 32'(bytes))) + 32'(i * bytes);
    endfunction

    // SIF sink back-pressure: always ready, random, or a 0,0,1 cadence.
    initial begin : sif_sink
        SIF_READY = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            case (rdy_mode)
                1:       SIF_READY = 1'($urandom_range(0, 1));
                2:       SIF_READY = ((cyc % 3) == 2);
                default: SIF_READY = 1'b1;
            endcase
        end
    end

    logic        prev_we  = 1'b0;
    logic        prev_rdy = 1'b0;
    logic        prev_rst = 1'b0;
    logic [31:0] prev_a   = '0;
    logic [7:0]  prev_s   = '0;
    logic [63:0] prev_d   = '0;

    // SIF monitor: scoreboard on commits, stability while stalled, WREADY while full.
    always @(negedge ACLK) begin : sif_monitor
        beat_t e;
        if (ARESETn && prev_rst && prev_we && !prev_rdy) begin
            chk("stall_we_held", 64'(SIF_WE), 64'd1);
            chk("stall_addr_held", 64'(SIF_ADDR), 64'(prev_a));
            chk("stall_strb_held", 64'(SIF_STRB), 64'(prev_s));
            chk("stall_data_held", SIF_DATA, prev_d);
        end
        if (ARESETn && SIF_WE && !SIF_READY)
            chk("wready_when_full", 64'(WREADY), 64'd0);
        if (ARESETn && SIF_WE && SIF_READY) begin
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 64'(SIF_WE), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sif_addr", 64'(SIF_ADDR), 64'(e.a));
                chk("sif_strb", 64'(SIF_STRB), 64'(e.s));
                chk("sif_data", SIF_DATA, e.d);
            end
        end
        prev_we  = SIF_WE;
        prev_rdy = SIF_READY;
        prev_rst = ARESETn;
        prev_a   = SIF_ADDR;
        prev_s   = SIF_STRB;
        prev_d   = SIF_DATA;
    end

    task automatic check_reset_outputs();
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_bresp", 64'(BRESP), 64'd0);
        chk("rst_bid", 64'(BID), 64'd0);
        chk("rst_sif_we", 64'(SIF_WE), 64'd0);
        chk("rst_sif_addr", 64'(SIF_ADDR), 64'd0);
        chk("rst_sif_strb", 64'(SIF_STRB), 64'd0);
        chk("rst_sif_data", SIF_DATA, 64'd0);
    endtask

    // One AXI write burst. Called and returns at posedge+1. The first W beat is
    // offered together with AW to confirm it is held off until AW is taken.
    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int strb_val,
                            input int wgap_max, input int bhold, input bit wlast_early,
                            input int abort_after, input bit check_tp);
        logic [63:0] d[256];
        logic [7:0]  s[256];
        bit          err;
        int          to;
        int          g;
        logic [1:0]  exp_bresp;
        err = ERR_EN && ((burst == 3) || (size > 3) ||
              ((burst == 2) && !((len == 1) || (len == 3) || (len == 7) || (len == 15))));
        for (int i = 0; i <= len; i++) begin
            d[i] = {$urandom, $urandom};
            s[i] = (strb_val < 0) ? 8'($urandom) : 8'(strb_val);
        end
        first_we = -1;
        last_we  = -1;
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = 8'(len);
        AWSIZE  = 3'(size);
        AWBURST = 2'(burst);
        AWVALID = 1'b1;
        WDATA   = d[0];
        WSTRB   = s[0];
        WLAST   = wlast_early ? 1'b0 : (len == 0);
        WVALID  = 1'b1;
        to = 0;
        forever begin
            @(negedge ACLK);
            chk("w_before_aw_stalled", 64'(WREADY), 64'd0);
            if (AWREADY) break;
            if (++to > 200) begin
                chk("aw_timeout", 64'(AWREADY), 64'd1);
                break;
            end
            @(posedge ACLK);
            #1;
        end
        @(posedge ACLK);
        #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i > 0) begin
                g = $urandom_range(0, wgap_max);
                if (g > 0) begin
                    WVALID = 1'b0;
                    repeat (g) begin
                        @(posedge ACLK);
                        #1;
                    end
                end
                WDATA  = d[i];
                WSTRB  = s[i];
                WLAST  = wlast_early ? (i == 1) : (i == len);
                WVALID = 1'b1;
            end
            to = 0;
            forever begin
                @(negedge ACLK);
                if (WREADY) break;
                if (++to > 200) begin
                    chk("w_timeout", 64'(WREADY), 64'd1);
                    break;
                end
                @(posedge ACLK);
                #1;
            end
            if (!err) exp_q.push_back('{ref_addr(addr, i, len, size, burst), s[i], d[i]});
            @(posedge ACLK);
            #1;
            if ((abort_after >= 0) && (i + 1 == abort_after)) begin
                WVALID = 1'b0;
                return;
            end
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        BREADY = 1'b0;
        to = 0;
        forever begin
            @(negedge ACLK);
            if (BVALID) break;
            if (++to > 500) begin
                chk("b_timeout", 64'(BVALID), 64'd1);
                break;
            end
            @(posedge ACLK);
            #1;
        end
        exp_bresp = (ERR_EN && (err || wlast_early)) ? 2'b10 : 2'b00;
        chk("bid", 64'(BID), 64'(id));
        chk("bresp", 64'(BRESP), 64'(exp_bresp));
        chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
        if (!err) chk("bvalid_after_last_we", 64'(cyc), 64'(last_we + 1));
        if (check_tp) chk("full_throughput", 64'(last_we - first_we), 64'(len));
        for (int k = 0; k < bhold; k++) begin
            @(posedge ACLK);
            #1;
            @(negedge ACLK);
            chk("bvalid_held", 64'(BVALID), 64'd1);
            chk("awready_low_in_resp", 64'(AWREADY), 64'd0);
        end
        @(posedge ACLK);
        #1;
        BREADY = 1'b1;
        @(negedge ACLK);
        chk("bvalid_before_hs", 64'(BVALID), 64'd1);
        @(posedge ACLK);
        #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        chk("bvalid_after_hs", 64'(BVALID), 64'd0);
        chk("awready_after_hs", 64'(AWREADY), 64'd1);
        @(posedge ACLK);
        #1;
    endtask

    initial begin : main
        int lens[4];
        int burst;
        int size;
        int len;
        lens[0] = 1; lens[1] = 3; lens[2] = 7; lens[3] = 15;

        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        @(negedge ACLK);
        check_reset_outputs();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;

        // INCR, back-to-back at full rate
        rdy_mode = 0;
        do_burst(4'h5, 32'h0000_1000, 3, 3, 1, -1, 0, 0, 1'b0, -1, 1'b1);
        // WRAP starting mid-span
        do_burst(4'hA, 32'h0000_1018, 3, 3, 2, -1, 0, 1, 1'b0, -1, 1'b1);
        // FIXED with constant upper-half strobes
        do_burst(4'h3, 32'h0000_2004, 2, 3, 0, 8'hF0, 0, 0, 1'b0, -1, 1'b1);
        // INCR rolling over the top of the address space
        do_burst(4'h1, 32'hFFFF_FFF0, 3, 3, 1, -1, 0, 0, 1'b0, -1, 1'b0);

        // SIF stalls 0,0,1 and a response held off for 5 cycles
        rdy_mode = 2;
        do_burst(4'h7, 32'h0000_3000, 5, 3, 1, -1, 0, 5, 1'b0, -1, 1'b0);
        rdy_mode = 1;
        do_burst(4'h9, 32'h0000_4010, 7, 2, 2, -1, 2, 2, 1'b0, -1, 1'b0);

        // Reset in the middle of an 8-beat burst, then a clean burst
        rdy_mode = 0;
        do_burst(4'hE, 32'h0000_5000, 7, 3, 1, -1, 0, 0, 1'b0, 2, 1'b0);
        ARESETn = 1'b0;
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        check_reset_outputs();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        exp_q.delete();
        repeat (2) begin
            @(negedge ACLK);
            chk("no_stale_b", 64'(BVALID), 64'd0);
            @(posedge ACLK);
            #1;
        end
        do_burst(4'h2, 32'h0000_6000, 3, 3, 1, -1, 0, 0, 1'b0, -1, 1'b1);

`ifdef AHA_SIF_WRITE_ERR_EN
        // Reserved burst: beats swallowed, SLVERR
        do_burst(4'h4, 32'h0000_7000, 3, 3, 3, -1, 0, 0, 1'b0, -1, 1'b0);
        // Early WLAST: all beats still written, SLVERR
        do_burst(4'h6, 32'h0000_8000, 3, 3, 1, -1, 0, 0, 1'b1, -1, 1'b0);
`endif

        // Randomised bursts
        for (int n = 0; n < 40; n++) begin
            rdy_mode = $urandom_range(0, 2);
            burst    = ERR_EN ? $urandom_range(0, 2) : $urandom_range(0, 3);
            size     = ERR_EN ? $urandom_range(0, 3) : $urandom_range(0, 5);
            len      = (burst == 2) ? lens[$urandom_range(0, 3)] : $urandom_range(0, 15);
            do_burst(4'($urandom), $urandom, len, size, burst, -1,
                     $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aha_axi_to_sif_write_burst.md
Name: aha_axi_to_sif_write_burst

Overview:
- Parametrised AXI4 write-channel slave that converts bursts into a registered, back-pressurable CGRA Simple Interface (SIF) write stream.
- Computes per-beat addresses for FIXED, INCR and WRAP bursts itself.
- Supports one outstanding burst and generic data width.
- Sits between the SoC AXI interconnect and the CGRA/global-buffer SIF write port. Successor to the fixed 64-bit, non-stallable SIF write bridge.

Parameters:
- DATA_W, 64, AXI/SIF data width in bits; power of two, 32..512.
- ADDR_W, 32, address width.
- ID_W, 4, AXI ID width.
- STRB_W, DATA_W/8, derived strobe width (localparam, not overridable).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- AWID  in  ID_W  write ID
- AWADDR  in  ADDR_W  burst start address
- AWLEN  in  8  beats-1
- AWSIZE  in  3  log2 bytes per beat
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- WDATA  in  DATA_W  write data
- WSTRB  in  STRB_W  byte strobes
- WLAST  in  1  last beat
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- BID  out  ID_W  response ID
- BRESP  out  2  response
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- SIF_ADDR  out  ADDR_W  beat byte address
- SIF_STRB  out  STRB_W  byte enables, active high
- SIF_DATA  out  DATA_W  write data
- SIF_WE  out  1  write request (valid)
- SIF_READY  in  1  SIF accepts write this cycle

Behaviour:
- Clock is ACLK. Reset ARESETn is synchronous, active-low.
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, SIF_WE=0, SIF_ADDR/STRB/DATA=0. The state machine goes to IDLE. An in-flight burst is dropped and produces no B response.
- FSM states: IDLE, DATA, DRAIN, RESP.
- IDLE:
  - AWREADY=1.
  - On AWVALID, latch ID, LEN, SIZE, BURST and ADDR, clear the beat counter, and go to DATA.
  - Compute the wrap boundary mask = ((LEN+1)<<SIZE)-1.
- DATA:
  - WREADY = !SIF_WE || SIF_READY.
  - On a W handshake, load the output register on the next edge: SIF_WE=1, with ADDR/STRB/DATA set. Latency is 1 cycle from W handshake to SIF_WE.
  - After a handshake, advance the address:
    - FIXED: unchanged.
    - INCR: (addr & ~((1<<SIZE)-1)) + (1<<SIZE).
    - WRAP: (addr & ~mask) | ((addr + (1<<SIZE)) & mask).
  - The beat counter is authoritative. When counter==LEN on a handshake, go to DRAIN. WLAST is otherwise ignored.
- Output register:
  - SIF_WE holds, with ADDR/STRB/DATA stable, until SIF_READY=1.
  - The register is cleared on SIF_READY unless a new beat loads it in the same cycle. This gives full throughput of one beat per cycle when SIF_READY is held high.
- DRAIN: WREADY=0. When SIF_WE && SIF_READY (last beat committed), go to RESP.
- RESP:
  - BVALID=1, BID=latched ID, BRESP=00 (OKAY).
  - On BREADY, deassert BVALID and go to IDLE. The next AW can be accepted the cycle after the B handshake.
- Arithmetic: address adds are modulo 2^ADDR_W. INCR crossing 4 KB is not checked; it wraps naturally.
- AWSIZE > log2(STRB_W) and reserved bursts are forwarded as INCR with clamped SIZE, unless the optional feature is enabled.
- AW arriving before or with W is both legal. W arriving before AW is stalled (WREADY=0 in IDLE).

Optional Feature:
- Macro: AHA_SIF_WRITE_ERR_EN.
- When defined:
  - Protocol checking is enabled.
  - A burst with reserved AWBURST, AWSIZE > log2(STRB_W), or WRAP with LEN not in {1,3,7,15} is flagged at AW time. All its beats are still accepted on W, but SIF_WE stays 0, and BRESP=10 (SLVERR).
  - If WLAST != (counter==LEN) on any beat, BRESP=10, while writes still proceed.
- When undefined: BRESP is always 00, no checks, and the error logic is absent.

Decomposition:
- Package aha_sif_pkg:
  - Burst type constants (BURST_FIXED/INCR/WRAP).
  - RESP_OKAY/RESP_SLVERR.
  - FSM state typedef.
  - Function next_beat_addr(addr, size, burst, mask).
- One natural sub-module: aha_sif_out_reg. It is the one-entry valid/ready output register (SIF_WE/SIF_READY skid) and is reusable for the read-side successor.

Test Plan:
- INCR, AWADDR=0x1000, LEN=3, SIZE=3, SIF_READY=1 → SIF_ADDR 0x1000/0x1008/0x1010/0x1018 on 4 consecutive cycles; BVALID 1 cycle after the last SIF_WE; BRESP=00, BID=AWID.
- WRAP, AWADDR=0x1018, LEN=3, SIZE=3 → SIF_ADDR 0x1018, 0x1000, 0x1008, 0x1010.
- FIXED, AWADDR=0x2004, LEN=2, WSTRB=0xF0 → three writes all at 0x2004 with SIF_STRB=0xF0.
- SIF_READY toggled 0,0,1 per beat → SIF_WE/ADDR/DATA stable while stalled, WREADY=0 while the register is full and not draining, no beat lost or duplicated; BREADY held low 5 cycles → BVALID held, AWREADY=0.
- ARESETn low mid-burst at beat 2 of 8 → next cycle all outputs at reset values; a new burst after reset completes normally with no stale B.
- With AHA_SIF_WRITE_ERR_EN: AWBURST=11 → SIF_WE never asserts, BRESP=10. WLAST early on beat 1 of LEN=3 → 4 writes occur, BRESP=10.
